// File: rtl/apb_req_arbiter.sv
// ----------------------------------------------------------------------------
// apb_req_arbiter
//   Shares one APB master command port among NUM_REQ requesters. In IDLE a
//   round-robin search from ptr picks a winner. Its command is latched and
//   driven for one transfer: ISSUE, then SETUP, then ACCESS. The owner gets
//   a one-cycle done pulse when the slave reports ready.
//
//   Optional feature: define APB_ARB_ADDR_CHECK_EN to reject winners whose
//   address is outside 0x1000_0000..0x1000_4FFF. A rejected winner is
//   completed at once with done+err and rdata=0, and no transfer is issued.
//   When the macro is undefined, err is constant 0.
//
// Ports
//   PCLK, PRESET          clock, asynchronous active-high reset
//   req[NUM_REQ]          request level, held until that requester's done
//   req_write[NUM_REQ]    1 = write, 0 = read
//   req_addr/req_wdata    NUM_REQ x 32, requester i in [32i+31:32i]
//   gnt[NUM_REQ]          one-hot current owner
//   done[NUM_REQ]         one-cycle completion pulse
//   err                   error flag, valid with any done bit
//   rdata[31:0]           read data, valid with done, held otherwise
//   m_transfer/m_write/m_addr/m_wdata -> APB master command
//   m_ready/m_rdata       <- APB master completion
// ----------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [31:0]            rdata,
  output logic                   m_transfer,
  output logic                   m_write,
  output logic [31:0]            m_addr,
  output logic [31:0]            m_wdata,
  input  logic                   m_ready,
  input  logic [31:0]            m_rdata
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  cmd_t               cmd_q, cmd_d;

  cmd_t               req_cmd [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic               pick_vld;
  logic [PW-1:0]      pick_idx;
  logic [PW-1:0]      cand;
  logic               addr_bad;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Unpack the flat command buses into per-requester records.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cmd[i].write = req_write[i];
      req_cmd[i].addr  = req_addr[32*i +: 32];
      req_cmd[i].wdata = req_wdata[32*i +: 32];
    end
  end

  // Round-robin search starting at ptr. A requester whose done pulse is
  // showing this cycle has not yet dropped req, so it is masked out here.
  always_comb begin
    elig     = req & ~done_q;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

`ifdef APB_ARB_ADDR_CHECK_EN
  function automatic logic in_range(input logic [31:0] a);
    return (a >= 32'h1000_0000) && (a <= 32'h1000_4FFF);
  endfunction

  assign addr_bad = !in_range(req_cmd[pick_idx].addr);
`else
  assign addr_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    cmd_d   = cmd_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          if (addr_bad) begin
            // Rejected without touching the master port; the latched command
            // from the previous grant stays on m_* untouched.
            done_d  = NUM_REQ'(1) << pick_idx;
            err_d   = 1'b1;
            rdata_d = '0;
            ptr_d   = ptr_next(pick_idx);
          end else begin
            win_d   = pick_idx;
            cmd_d   = req_cmd[pick_idx];
            gnt_d   = NUM_REQ'(1) << pick_idx;
            state_d = ISSUE;
          end
        end
      end
      ISSUE:  state_d = SETUP;
      // The master is still in its setup phase; a ready here is meaningless.
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (m_ready) begin
          rdata_d = m_rdata;
          done_d  = gnt_q;
          gnt_d   = '0;
          ptr_d   = ptr_next(win_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cmd_q   <= cmd_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign m_transfer = (state_q == ISSUE);
  assign m_write    = cmd_q.write;
  assign m_addr     = cmd_q.addr;
  assign m_wdata    = cmd_q.wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios followed by randomized
// request traffic, checked against a transaction-level reference model.
module tb_apb_req_arbiter;
  localparam int N = 4;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic [N-1:0]      req, req_write, gnt, done;
  logic [N*32-1:0]   req_addr, req_wdata;
  logic              err, m_transfer, m_write, m_ready;
  logic [31:0]       rdata, m_addr, m_wdata, m_rdata;

  apb_req_arbiter #(.NUM_REQ(N)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .m_transfer(m_transfer), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Requester-side drive values
  logic        r_req [N];
  logic        r_write [N];
  logic [31:0] r_addr [N];
  logic [31:0] r_wdata [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i]               = r_req[i];
      req_write[i]         = r_write[i];
      req_addr[32*i +: 32] = r_addr[i];
      req_wdata[32*i +: 32] = r_wdata[i];
    end
  end

  // Reference model: pending set, the command each requester posted,
  // rotation pointer and the requester completed in the current cycle.
  logic [N-1:0] pend, ldmask;
  int           mptr;
  logic        a_write [N];
  logic [31:0] a_addr [N];
  logic [31:0] a_wdata [N];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  // First set member at or after p, wrapping.
  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    int mi;
    mi = int'(m);
    for (int k = 0; k < N; k++) begin
      if (((mi >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic raise(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    r_req[i] = 1'b1; r_write[i] = w; r_addr[i] = a; r_wdata[i] = d;
    a_write[i] = w; a_addr[i] = a; a_wdata[i] = d;
    pend = pend | oh(i);
  endtask

  function automatic logic [31:0] good_addr();
    return 32'h1000_0000 + ($urandom_range(0, 32'h4FFF) & 32'hFFFF_FFFC);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(gnt), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_err"},   32'(err), 0);
    chk({tag, "_xfer"},  32'(m_transfer), 0);
    chk({tag, "_mwr"},   32'(m_write), 0);
    chk({tag, "_maddr"}, m_addr, 0);
    chk({tag, "_mwd"},   m_wdata, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  // One transaction, entered at the negedge of an IDLE cycle t0 in which the
  // current pending set is presented. Returns at the negedge of the done cycle.
  task automatic txn(input int t0, input int w, input logic [31:0] rd, input bit hold);
    logic [N-1:0] e;
    int gap, win, k;
    e   = pend & ~ldmask;
    gap = (e != 0) ? 1 : 2;
    if (e == 0) e = pend;
    win = rr_pick(e, mptr);
    k = 0;
    while (gnt == '0 && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    if (gnt == '0) begin
      chk("gnt_wait", 32'(gnt), 32'(oh(win)));
      return;
    end
    chk("lat_gnt",   32'(cyc - t0), 32'(gap));
    chk("gnt",       32'(gnt), 32'(oh(win)));
    chk("xfer_iss",  32'(m_transfer), 1);
    chk("m_write",   32'(m_write), 32'(a_write[win]));
    chk("m_addr",    m_addr, a_addr[win]);
    chk("m_wdata",   m_wdata, a_wdata[win]);
    m_ready = 1'($urandom);
    @(negedge PCLK);
    chk("xfer_setup", 32'(m_transfer), 0);
    chk("gnt_setup",  32'(gnt), 32'(oh(win)));
    m_ready = 1'($urandom);
    for (int i = 0; i <= w; i++) begin
      @(negedge PCLK);
      chk("xfer_acc",   32'(m_transfer), 0);
      chk("done_early", 32'(done), 0);
      chk("gnt_acc",    32'(gnt), 32'(oh(win)));
      chk("addr_hold",  m_addr, a_addr[win]);
      chk("wdata_hold", m_wdata, a_wdata[win]);
      chk("write_hold", 32'(m_write), 32'(a_write[win]));
      if (!hold) begin
        r_addr[win] = $urandom; r_wdata[win] = $urandom; r_write[win] = 1'($urandom);
      end
      m_ready = (i == w);
      m_rdata = (i == w) ? rd : $urandom;
    end
    @(negedge PCLK);
    m_ready = 1'b0;
    chk("done",      32'(done), 32'(oh(win)));
    chk("rdata",     rdata, rd);
    chk("err",       32'(err), 0);
    chk("gnt_clr",   32'(gnt), 0);
    chk("lat_done",  32'(cyc - t0), 32'(gap + 3 + w));
    mptr   = (win + 1) % N;
    ldmask = oh(win);
    if (!hold) begin
      pend = pend & ~oh(win);
      r_req[win] = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      r_req[i] = 0; r_write[i] = 0; r_addr[i] = 0; r_wdata[i] = 0;
      a_write[i] = 0; a_addr[i] = 0; a_wdata[i] = 0;
    end
    m_ready = 0; m_rdata = 0;
    pend = '0; ldmask = '0; mptr = 0;

    repeat (3) @(negedge PCLK);
    chk_all_zero("reset");
    PRESET = 1'b0;
    @(negedge PCLK);

    // Single read, zero-wait slave
    raise(0, 1'b0, 32'h1000_0004, 32'h0);
    txn(cyc, 0, 32'h1234_5678, 0);
    @(negedge PCLK);
    chk("rdata_hold", rdata, 32'h1234_5678);
    chk("done_clr",   32'(done), 0);
    ldmask = '0;

    // Write with three wait states
    raise(2, 1'b1, 32'h1000_2000, 32'hA5A5_A5A5);
    txn(cyc, 3, $urandom, 0);
    @(negedge PCLK);
    ldmask = '0;

    // Out-of-range address from requester 3 (pointer now at 3)
    raise(3, 1'b0, 32'h2000_0000, 32'h0);
`ifdef APB_ARB_ADDR_CHECK_EN
    @(negedge PCLK);
    chk("ac_done",  32'(done), 32'(oh(3)));
    chk("ac_err",   32'(err), 1);
    chk("ac_rdata", rdata, 0);
    chk("ac_xfer",  32'(m_transfer), 0);
    chk("ac_gnt",   32'(gnt), 0);
    r_req[3] = 0; pend = pend & ~oh(3); mptr = 0;
    @(negedge PCLK);
    chk("ac_idle_xfer", 32'(m_transfer), 0);
    chk("ac_idle_done", 32'(done), 0);
`else
    txn(cyc, 0, $urandom, 0);
    @(negedge PCLK);
`endif
    ldmask = '0;
    // Pointer must have moved past 3, so 1 beats 3 now
    raise(1, 1'b1, good_addr(), $urandom);
    raise(3, 1'b0, good_addr(), $urandom);
    txn(cyc, 1, $urandom, 0);
    txn(cyc, 0, $urandom, 0);

    // Reset in the middle of an ACCESS owned by requester 1
    @(negedge PCLK);
    ldmask = '0;
    raise(1, 1'b1, 32'h1000_0100, 32'hDEAD_BEEF);
    repeat (3) @(negedge PCLK);
    chk("pre_rst_gnt", 32'(gnt), 32'(oh(1)));
    PRESET = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge PCLK);
    chk("midrst_done", 32'(done), 0);
    PRESET = 1'b0; mptr = 0; ldmask = '0;
    raise(0, 1'b0, good_addr(), $urandom);
    txn(cyc, 1, $urandom, 0);
    txn(cyc, 0, $urandom, 0);

    // Full contention with every requester holding req
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0; mptr = 0; ldmask = '0; pend = '0;
    for (int i = 0; i < N; i++) raise(i, 1'($urandom), good_addr(), $urandom);
    for (int n = 0; n < 5; n++) txn(cyc, $urandom_range(0, 2), $urandom, 1);
    for (int i = 0; i < N; i++) r_req[i] = 0;
    pend = '0;

    // Randomized traffic
    @(negedge PCLK);
    ldmask = '0;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) begin
        if (((int'(pend) >> i) & 1) == 0 && ($urandom % 2) == 1)
          raise(i, 1'($urandom), good_addr(), $urandom);
      end
      if (pend == '0) raise($urandom_range(0, N-1), 1'($urandom), good_addr(), $urandom);
      txn(cyc, $urandom_range(0, 3), $urandom, 0);
    end

    @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one APB master command port (2..8).
REQ-002 SHALL have port PCLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port PRESET, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port req, input, NUM_REQ bits, per-requester request level, held until that requester's done.
REQ-005 SHALL have port req_write, input, NUM_REQ bits, per-requester write(1)/read(0).
REQ-006 SHALL have port req_addr, input, NUM_REQ*32 bits, requester i in bits [32i+31:32i].
REQ-007 SHALL have port req_wdata, input, NUM_REQ*32 bits, packed as req_addr.
REQ-008 SHALL have port gnt, output, NUM_REQ bits, one-hot current owner of the master port.
REQ-009 SHALL have port done, output, NUM_REQ bits, one-cycle completion pulse to the owner.
REQ-010 SHALL have port err, output, 1 bit, error flag qualified by any done bit.
REQ-011 SHALL have port rdata, output, 32 bits, read data valid while done is asserted.
REQ-012 SHALL have ports m_transfer (out, 1), m_write (out, 1), m_addr (out, 32), m_wdata (out, 32), m_ready (in, 1), m_rdata (in, 32), connecting to the APB master internal interface.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, SETUP, ACCESS.
REQ-014 In IDLE with any eligible req, SHALL select the winner round-robin starting from pointer ptr, latch its write/addr/wdata into registers, set gnt one-hot, and go to ISSUE.
REQ-015 A requester whose done bit is high in the current cycle SHALL be ineligible in that cycle.
REQ-016 ISSUE SHALL assert m_transfer for exactly one cycle, then go to SETUP; m_transfer SHALL be 0 in all other states.
REQ-017 SETUP SHALL ignore m_ready and go to ACCESS.
REQ-018 ACCESS SHALL wait indefinitely for m_ready=1; on it, SHALL register m_rdata into rdata, pulse the winner's done bit in the next cycle, clear gnt, set ptr to winner+1 modulo NUM_REQ, and return to IDLE.
REQ-019 m_write, m_addr, m_wdata SHALL be driven only from the latched registers and SHALL remain stable from ISSUE until the next grant.
REQ-020 Latency with zero-wait slave: req high in IDLE at cycle t, m_transfer at t+1, done at t+4.
REQ-021 Simultaneous requests SHALL be served one per transaction in round-robin order; no requester waits more than NUM_REQ-1 transactions.
REQ-022 Changes to req or command inputs during ISSUE, SETUP, or ACCESS SHALL NOT affect the transaction in progress.
REQ-023 rdata SHALL hold its last value outside done pulses; for writes, rdata SHALL be the captured m_rdata (don't-care to the requester).

Reset
REQ-024 On PRESET, state SHALL be IDLE, ptr 0, and gnt, done, err, m_transfer, m_write, m_addr, m_wdata, and rdata all 0, including when PRESET asserts mid-transaction; no done SHALL be issued for an aborted transaction.

Configuration
REQ-025 Macro APB_ARB_ADDR_CHECK_EN SHALL gate the address-range check.
REQ-026 With APB_ARB_ADDR_CHECK_EN defined, a winner whose addr lies outside 0x1000_0000..0x1000_4FFF SHALL NOT be issued: the block SHALL stay in IDLE, pulse done with err=1 and rdata=0 in the next cycle, and advance ptr.
REQ-027 With APB_ARB_ADDR_CHECK_EN undefined, all requests SHALL be forwarded and err SHALL be constant 0.

Verification
REQ-028 Single read: req[0], addr 0x1000_0004, slave ready in first ACCESS cycle, m_rdata 0x1234_5678 -> m_transfer at t+1, done[0] at t+4, rdata=0x1234_5678, err=0.
REQ-029 Wait states: write from req[2], addr 0x1000_2000, wdata 0xA5A5_A5A5, m_ready delayed 3 cycles -> m_addr/m_wdata/m_write stable throughout, done[2] at t+7.
REQ-030 Contention: req=4'b1111 held after reset -> grant order 0,1,2,3,0, exactly one gnt bit at a time, no back-to-back grant to a requester just done.
REQ-031 Reset mid-ACCESS: PRESET pulsed while gnt[1]=1 -> all outputs 0, no done[1], next grant goes to requester 0.
REQ-032 Address check: with macro defined, req[3] addr 0x2000_0000 -> no m_transfer, done[3] with err=1 at t+1, ptr advances; with macro undefined, m_transfer issues and err stays 0.
